// File: rtl/afifo_pkg.sv
// Shared types and defaults for the async FIFO read-side drain logic.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package afifo_pkg;
    localparam int DATA_WIDTH_DEF = `DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;
endpackage

// File: rtl/afifo_skid_buf.sv
// Two-entry register FIFO that catches words returning from the async FIFO
// one cycle after each pop, so downstream stalls never lose data.
module afifo_skid_buf #(
    parameter int DW = 8
) (
    input  logic          rclk,
    input  logic          rrst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head
);
    logic [DW-1:0] r_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_occ;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge rclk) begin
                if (!rrst_n) begin
                    r_mem[gi] <= '0;
                end else if (push && (r_wr_ptr == 1'(gi))) begin
                    r_mem[gi] <= push_data;
                end
            end
        end
    endgenerate

    // Push and pop in the same cycle move both pointers and leave occupancy alone.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (push) r_wr_ptr <= ~r_wr_ptr;
            if (pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({push, pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign occ  = r_occ;
    assign head = r_mem[r_rd_ptr];
endmodule

// File: rtl/afifo_rd_drain.sv
// Read-domain consumer: turns the FIFO pop interface into a valid/ready stream,
// issuing pops only when the skid buffer is guaranteed room for the returning word.
module afifo_rd_drain
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pop_count
);
    drain_state_e          r_state;
    logic                  r_inflight;
    logic [CNT_WIDTH-1:0]  r_pop_count;

    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_deq;
    logic [2:0]            w_credit;
    logic                  w_rinc;

    assign w_deq = m_valid && m_ready;
    // Slots committed after this edge; deq only happens with occ>=1, so no underflow.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_deq};
    assign w_rinc   = rrst_n && enable && (r_state == RUN) && !rempty && (w_credit < 3'd2);

    afifo_skid_buf #(
        .DW(DATA_WIDTH)
    ) u_skid (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .push      (r_inflight),
        .push_data (rdata),
        .pop       (w_deq),
        .occ       (w_occ),
        .head      (w_head)
    );

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            r_state     <= IDLE;
            r_inflight  <= 1'b0;
            r_pop_count <= '0;
        end else begin
            r_inflight <= w_rinc;
            if (w_rinc) r_pop_count <= r_pop_count + CNT_WIDTH'(1);
            case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= DRAIN;
                DRAIN: begin
                    if (enable)                                r_state <= RUN;
                    else if ((w_occ == 2'd0) && !r_inflight)   r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rinc      = w_rinc;
    assign m_valid   = (w_occ != 2'd0);
    assign m_data    = w_head;
    assign busy      = (r_state != IDLE);
    assign pop_count = r_pop_count;
endmodule
